// File: rtl/wb_commit_pkg.sv
// Shared writeback-stage types: per-lane commit bundle, commit FSM states, lane limit.
package wb_commit_pkg;

   localparam int MAX_LANES = 2;

   typedef struct packed {
      logic        vld;
      logic        wen;
      logic [4:0]  regw;
      logic [31:0] valA;
      logic [31:0] valB;
      logic        hi_r;
      logic        lo_r;
      logic        hi_w;
      logic        lo_w;
      logic        rm;
   } wb_lane_t;

   typedef enum logic [1:0] {
      ST_EMPTY     = 2'd0,
      ST_COMMIT    = 2'd1,
      ST_WAIT_LOAD = 2'd2
   } wb_state_t;

endpackage

// File: rtl/wb_lane_sel.sv
// One lane's register-file write enable and write-data mux (load / HI / LO / ALU result).
module wb_lane_sel
   import wb_commit_pkg::*;
#(
   parameter bit HONOR_RM = 1'b0
) (
   input  wb_lane_t    lane,
   input  logic [31:0] load_data,
   input  logic [31:0] hi_src,
   input  logic [31:0] lo_src,
   output logic        we,
   output logic [31:0] wd
);

   logic load_sel;

   // Only the lane wired to the data port may take its result from memory.
   assign load_sel = HONOR_RM && lane.vld && lane.rm;
   assign we       = lane.vld && lane.wen && (lane.regw != 5'd0);

   always_comb begin
      wd = lane.valA;
      if (load_sel)       wd = load_data;
      else if (lane.hi_r) wd = hi_src;
      else if (lane.lo_r) wd = lo_src;
   end

endmodule

// File: rtl/wb_commit.sv
// Writeback commit stage: single bundle register, stalls on a lane-0 load until data returns.
module wb_commit
   import wb_commit_pkg::*;
#(
   parameter int LANES = 2,
   parameter int CNT_W = 32
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  wb_lane_t [LANES-1:0]        in_lane,
   input  logic                        dresp_ok,
   input  logic [31:0]                 dresp_data,
   output logic [LANES-1:0]            rf_we,
   output logic [LANES-1:0][4:0]       rf_wa,
   output logic [LANES-1:0][31:0]      rf_wd,
   output logic [31:0]                 hi_q,
   output logic [31:0]                 lo_q,
   output logic [CNT_W-1:0]            retired
);

   if (LANES < 1 || LANES > MAX_LANES) begin : g_bad_lanes
      $error("wb_commit: LANES out of range");
   end

   wb_state_t              state, state_nx;
   wb_lane_t [LANES-1:0]   w_lane;
   logic                   accept, commit, dup0;
   logic [LANES-1:0]       we_raw;
   logic [LANES:0][31:0]   hi_chain, lo_chain;
   logic [CNT_W-1:0]       nvld;

   assign accept = in_valid && in_ready;

   always_comb begin
      state_nx = state;
      in_ready = 1'b1;
      commit   = 1'b0;
      case (state)
         ST_EMPTY: state_nx = accept ? (in_lane[0].vld && in_lane[0].rm ? ST_WAIT_LOAD : ST_COMMIT)
                                     : ST_EMPTY;
         ST_COMMIT: begin
            commit   = 1'b1;
            state_nx = accept ? (in_lane[0].vld && in_lane[0].rm ? ST_WAIT_LOAD : ST_COMMIT)
                              : ST_EMPTY;
         end
         ST_WAIT_LOAD: begin
            in_ready = 1'b0;
            commit   = dresp_ok;
            if (dresp_ok) state_nx = ST_EMPTY;
         end
         default: state_nx = ST_EMPTY;
      endcase
   end

   // HI/LO forward through the lanes in program order so lane 1 sees lane 0's update.
   assign hi_chain[0] = hi_q;
   assign lo_chain[0] = lo_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign hi_chain[i+1] = (w_lane[i].vld && w_lane[i].hi_w) ? w_lane[i].valA : hi_chain[i];
      assign lo_chain[i+1] = (w_lane[i].vld && w_lane[i].lo_w) ? w_lane[i].valB : lo_chain[i];
      assign rf_wa[i]      = w_lane[i].regw;

      wb_lane_sel #(.HONOR_RM(i == 0)) u_sel (
         .lane      (w_lane[i]),
         .load_data (dresp_data),
         .hi_src    (hi_chain[i]),
         .lo_src    (lo_chain[i]),
         .we        (we_raw[i]),
         .wd        (rf_wd[i])
      );
   end

   // Same-register collision: the younger lane's write is the architectural one.
   if (LANES > 1) begin : g_dup
      assign dup0 = we_raw[0] && we_raw[1] && (w_lane[0].regw == w_lane[1].regw);
   end else begin : g_nodup
      assign dup0 = 1'b0;
   end

   always_comb begin
      rf_we = commit ? we_raw : '0;
      if (dup0) rf_we[0] = 1'b0;
   end

   always_comb begin
      nvld = '0;
      for (int i = 0; i < LANES; i++) nvld = nvld + CNT_W'(w_lane[i].vld);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= ST_EMPTY;
         w_lane  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         retired <= '0;
      end else begin
         state <= state_nx;
         if (accept) w_lane <= in_lane;
         if (commit) begin
            hi_q    <= hi_chain[LANES];
            lo_q    <= lo_chain[LANES];
            retired <= retired + nvld;
         end
      end
   end

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: expected writes queued at issue, checked by a negedge monitor.
module tb_wb_commit;
   import wb_commit_pkg::*;

   localparam int LANES = 2;
   localparam int CNT_W = 3;

   logic                   clk = 1'b0;
   logic                   resetn;
   logic                   in_valid;
   logic                   in_ready;
   wb_lane_t [LANES-1:0]   in_lane;
   logic                   dresp_ok;
   logic [31:0]            dresp_data;
   logic [LANES-1:0]       rf_we;
   logic [LANES-1:0][4:0]  rf_wa;
   logic [LANES-1:0][31:0] rf_wd;
   logic [31:0]            hi_q, lo_q;
   logic [CNT_W-1:0]       retired;

   typedef struct {
      logic [1:0]       we;
      logic [1:0][4:0]  wa;
      logic [1:0][31:0] wd;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   wb_commit #(.LANES(LANES), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .in_lane(in_lane), .dresp_ok(dresp_ok), .dresp_data(dresp_data),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .hi_q(hi_q), .lo_q(lo_q), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // flags = {hi_r, lo_r, hi_w, lo_w, rm}; vld and wen always set
   function automatic wb_lane_t ln(input logic [4:0] regw, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] flags);
      wb_lane_t l;
      l      = '0;
      l.vld  = 1'b1;
      l.wen  = 1'b1;
      l.regw = regw;
      l.valA = a;
      l.valB = b;
      {l.hi_r, l.lo_r, l.hi_w, l.lo_w, l.rm} = flags;
      return l;
   endfunction

   task automatic push(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1);
      exp_t e;
      e.we = we;
      e.wa[0] = wa0; e.wd[0] = wd0;
      e.wa[1] = wa1; e.wd[1] = wd1;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Caller sits just after a rising edge; returns just after the accepting edge.
   task automatic send(input wb_lane_t l0, input wb_lane_t l1);
      in_valid   = 1'b1;
      in_lane[0] = l0;
      in_lane[1] = l1;
      tick();
      in_valid = 1'b0;
      in_lane  = '0;
   endtask

   always @(negedge clk) begin
      if (rf_we != '0) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got we=%b wa0=%0d wa1=%0d expected no write",
                     rf_we, rf_wa[0], rf_wa[1]);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rf_we", 32'(rf_we), 32'(e.we));
            for (int i = 0; i < LANES; i++) begin
               if (e.we[i]) begin
                  chk($sformatf("rf_wa[%0d]", i), 32'(rf_wa[i]), 32'(e.wa[i]));
                  chk($sformatf("rf_wd[%0d]", i), rf_wd[i], e.wd[i]);
               end
            end
         end
      end
   end

   initial begin
      resetn     = 1'b0;
      in_valid   = 1'b0;
      in_lane    = '0;
      dresp_ok   = 1'b0;
      dresp_data = '0;
      #12;
      chk("reset rf_we", 32'(rf_we), 0);
      chk("reset hi_q", hi_q, 0);
      chk("reset lo_q", lo_q, 0);
      chk("reset retired", 32'(retired), 0);
      tick();
      resetn = 1'b1;
      tick();
      chk("in_ready after reset", 32'(in_ready), 1);

      // single ALU lane
      push(2'b01, 5'd3, 32'h1234, 5'd0, 32'h0);
      send(ln(5'd3, 32'h1234, 32'h0, 5'b00000), '0);
      tick();
      chk("alu retired", 32'(retired), 1);

      // lane 0 writes HI, lane 1 reads the forwarded value
      push(2'b11, 5'd1, 32'hAAAA0000, 5'd2, 32'hAAAA0000);
      send(ln(5'd1, 32'hAAAA0000, 32'h0, 5'b00100), ln(5'd2, 32'h0, 32'h0, 5'b10000));
      tick();
      chk("hi fwd hi_q", hi_q, 32'hAAAA0000);
      chk("hi fwd retired", 32'(retired), 3);

      // LO from valB, forwarded to lane 1
      push(2'b11, 5'd4, 32'h11, 5'd6, 32'h55);
      send(ln(5'd4, 32'h11, 32'h55, 5'b00010), ln(5'd6, 32'h0, 32'h0, 5'b01000));
      tick();
      chk("lo fwd lo_q", lo_q, 32'h55);
      chk("lo fwd hi_q", hi_q, 32'hAAAA0000);
      chk("lo fwd retired", 32'(retired), 5);

      // both lanes write HI: lane 0 reads old, lane 1 reads lane 0's, lane 1 wins
      push(2'b11, 5'd8, 32'hAAAA0000, 5'd9, 32'h1);
      send(ln(5'd8, 32'h1, 32'h0, 5'b10100), ln(5'd9, 32'h2, 32'h0, 5'b10100));
      tick();
      chk("hi both hi_q", hi_q, 32'h2);
      chk("hi both retired", 32'(retired), 7);

      // same destination: only lane 1 writes; retired wraps 7+2 -> 1
      push(2'b10, 5'd0, 32'h0, 5'd7, 32'h2);
      send(ln(5'd7, 32'h1, 32'h0, 5'b00000), ln(5'd7, 32'h2, 32'h0, 5'b00000));
      tick();
      chk("wrap retired", 32'(retired), 1);

      // regw 0 never writes; lane-1 rm and stray dresp_ok ignored
      dresp_ok   = 1'b1;
      dresp_data = 32'hBAD0BAD0;
      push(2'b10, 5'd0, 32'h0, 5'd10, 32'h77);
      send(ln(5'd0, 32'h33, 32'h0, 5'b00000), ln(5'd10, 32'h77, 32'h0, 5'b00001));
      chk("lane1 rm in_ready", 32'(in_ready), 1);
      tick();
      dresp_ok = 1'b0;
      chk("r0 retired", 32'(retired), 3);

      // back-to-back, no bubbles
      for (int k = 0; k < 3; k++) begin
         push(2'b01, 5'(11 + k), 32'h100 + 32'(k), 5'd0, 32'h0);
         in_valid   = 1'b1;
         in_lane[0] = ln(5'(11 + k), 32'h100 + 32'(k), 32'h0, 5'b00000);
         in_lane[1] = '0;
         chk($sformatf("b2b in_ready %0d", k), 32'(in_ready), 1);
         tick();
      end
      in_valid = 1'b0;
      in_lane  = '0;
      tick();
      chk("b2b retired", 32'(retired), 6);

      // lane-0 load waits three cycles for data
      send(ln(5'd5, 32'h999, 32'h0, 5'b00001), ln(5'd12, 32'h44, 32'h0, 5'b00000));
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("load wait in_ready %0d", k), 32'(in_ready), 0);
         tick();
      end
      dresp_ok   = 1'b1;
      dresp_data = 32'hDEADBEEF;
      push(2'b11, 5'd5, 32'hDEADBEEF, 5'd12, 32'h44);
      tick();
      dresp_ok = 1'b0;
      chk("load retired", 32'(retired), 0);
      chk("load in_ready", 32'(in_ready), 1);

      // reset while waiting on a load discards it
      send(ln(5'd13, 32'hF0F0, 32'h0F0F, 5'b00111), '0);
      tick();
      chk("pre-reset in_ready", 32'(in_ready), 0);
      resetn     = 1'b0;
      dresp_ok   = 1'b1;
      dresp_data = 32'h12345678;
      #1;
      chk("mid reset rf_we", 32'(rf_we), 0);
      tick();
      resetn = 1'b1;
      tick();
      dresp_ok = 1'b0;
      chk("post reset in_ready", 32'(in_ready), 1);
      chk("post reset hi_q", hi_q, 0);
      chk("post reset lo_q", lo_q, 0);
      chk("post reset retired", 32'(retired), 0);

      push(2'b01, 5'd14, 32'hCAFE, 5'd0, 32'h0);
      send(ln(5'd14, 32'hCAFE, 32'h0, 5'b00000), '0);
      tick();
      chk("after reset retired", 32'(retired), 1);

      tick();
      tick();
      chk("scoreboard drained", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
